// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the adder-side blocks: word format, constants and the
// accumulator master FSM encoding.
package fp16_pkg;

   localparam int REG_SIZE = 16;
   localparam int EXP_SIZE = 5;
   localparam int FRA_SIZE = 10;
   localparam int BIAS     = (1 << (EXP_SIZE - 1)) - 1;

   localparam logic [REG_SIZE-1:0] FP16_ZERO = 16'h0000;
   localparam logic [REG_SIZE-1:0] FP16_ONE  = 16'h3C00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_WAIT,
      ST_CAPTURE,
      ST_EMIT
   } accum_state_e;

endpackage : fp16_pkg

// File: rtl/fp16_lat_timer.sv
// Load/decrement down-counter that times the adder latency; done_o is high while the
// count sits at zero.
module fp16_lat_timer #(
   parameter int ADD_LATENCY = 8
) (
   input  logic clk_44,
   input  logic reset_44,
   input  logic load_i,
   input  logic dec_i,
   output logic done_o
);

   localparam int                CNT_W    = (ADD_LATENCY > 2) ? $clog2(ADD_LATENCY) : 1;
   localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(ADD_LATENCY - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_44 or negedge reset_44) begin
      if (!reset_44) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule : fp16_lat_timer

// File: rtl/fp16_accum_master.sv
// Folds each valid/ready packet of FP16 values into one sum by issuing operand pairs to
// the external FP16 adder, capturing every result, and emitting the final sum.
module fp16_accum_master #(
   parameter int REG_SIZE    = fp16_pkg::REG_SIZE,
   parameter int EXP_SIZE    = fp16_pkg::EXP_SIZE,
   parameter int FRA_SIZE    = fp16_pkg::FRA_SIZE,
   parameter int ADD_LATENCY = 8
) (
   input  logic                clk_44,
   input  logic                reset_44,
   input  logic                in_valid_44,
   output logic                in_ready_44,
   input  logic [REG_SIZE-1:0] in_data_44,
   input  logic                in_last_44,
   output logic                out_valid_44,
   input  logic                out_ready_44,
   output logic [REG_SIZE-1:0] out_data_44,
   output logic [REG_SIZE-1:0] addIn1_44,
   output logic [REG_SIZE-1:0] addIn2_44,
   output logic                data_incoming_44,
   input  logic [REG_SIZE-1:0] addOut_44
);

   import fp16_pkg::*;

   typedef struct packed {
      logic                sign;
      logic [EXP_SIZE-1:0] exp;
      logic [FRA_SIZE-1:0] frac;
   } fp_word_t;

   accum_state_e        state_q, state_d;
   logic                collect_q, collect_d;
   logic                last_q, last_d;
   fp_word_t            acc_q, acc_d;
   logic [REG_SIZE-1:0] op1_q, op1_d;
   logic [REG_SIZE-1:0] op2_q, op2_d;
   logic                in_ready_q;
   logic                out_valid_q;
   logic                strobe_q;

   logic                in_hs;
   logic                out_hs;
   logic                timer_load;
   logic                timer_done;

   assign in_hs  = in_valid_44 && in_ready_q;
   assign out_hs = out_valid_q && out_ready_44;

   fp16_lat_timer #(
      .ADD_LATENCY (ADD_LATENCY)
   ) u_lat_timer (
      .clk_44   (clk_44),
      .reset_44 (reset_44),
      .load_i   (timer_load),
      .dec_i    (state_q == ST_WAIT),
      .done_o   (timer_done)
   );

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      collect_d  = collect_q;
      last_d     = last_q;
      acc_d      = acc_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      timer_load = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_hs) begin
               if (!collect_q) begin
                  acc_d = fp_word_t'(in_data_44);
                  if (in_last_44) begin
                     state_d = ST_EMIT;
                  end else begin
                     collect_d = 1'b1;
                  end
               end else begin
                  op1_d   = acc_q;
                  op2_d   = in_data_44;
                  last_d  = in_last_44;
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
         end
         ST_STROBE: begin
            timer_load = 1'b1;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (timer_done) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            acc_d = fp_word_t'(addOut_44);
            if (last_q) begin
               collect_d = 1'b0;
               state_d   = ST_EMIT;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_EMIT: begin
            if (out_hs) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Handshake/strobe outputs are registered from the next state so they align with it
   // and come out of reset at zero.
   always_ff @(posedge clk_44 or negedge reset_44) begin
      if (!reset_44) begin
         state_q     <= ST_IDLE;
         collect_q   <= 1'b0;
         last_q      <= 1'b0;
         acc_q       <= fp_word_t'(FP16_ZERO);
         op1_q       <= FP16_ZERO;
         op2_q       <= FP16_ZERO;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         strobe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         collect_q   <= collect_d;
         last_q      <= last_d;
         acc_q       <= acc_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         in_ready_q  <= (state_d == ST_IDLE);
         out_valid_q <= (state_d == ST_EMIT);
         strobe_q    <= (state_d == ST_STROBE);
      end
   end

   assign in_ready_44      = in_ready_q;
   assign out_valid_44     = out_valid_q;
   assign out_data_44      = acc_q;
   assign addIn1_44        = op1_q;
   assign addIn2_44        = op2_q;
   assign data_incoming_44 = strobe_q;

endmodule : fp16_accum_master
